// File: rtl/stdp_pkg.sv
// Shared types and arithmetic helpers for the STDP learning array.
// Provides clog2, default age/weight typedefs, saturating add/sub and decay shift.
package stdp_pkg;

  localparam int TIMER_W_DEF  = 4;
  localparam int WEIGHT_W_DEF = 8;

  typedef logic [TIMER_W_DEF-1:0]  age_t;
  typedef logic [WEIGHT_W_DEF-1:0] weight_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

  function automatic int unsigned decay(
    input int unsigned amp,
    input int unsigned dt,
    input int unsigned tau
  );
    return amp >> (dt >> tau);
  endfunction

  function automatic int unsigned sat_add(
    input int unsigned w,
    input int unsigned d,
    input int unsigned wmax
  );
    int unsigned s;
    s = w + d;
    return (s > wmax) ? wmax : s;
  endfunction

  function automatic int unsigned sat_sub(
    input int unsigned w,
    input int unsigned d
  );
    return (w > d) ? (w - d) : 0;
  endfunction

endpackage

// File: rtl/stdp_channel.sv
// One presynaptic channel: saturating spike-age timer, weight register, LTP/LTD update.
// Ports: i_clk/i_rst, i_pre/i_post/i_learn spikes, i_post_age, i_wr/i_wr_data host write,
// o_weight current weight, o_upd learning changed this channel (combinational).
// LTD path built only when STDP_LTD_EN is defined.
module stdp_channel
  import stdp_pkg::*;
#(
  parameter int unsigned TIMER_W   = 4,
  parameter int unsigned WEIGHT_W  = 8,
  parameter int unsigned W_INIT    = 128,
  parameter int unsigned LTP_AMP   = 16,
  parameter int unsigned LTD_AMP   = 8,
  parameter int unsigned TAU_SHIFT = 1,
  parameter int unsigned WINDOW    = 8
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_pre,
  input  logic                i_post,
  input  logic                i_learn,
  input  logic [TIMER_W-1:0]  i_post_age,
  input  logic                i_wr,
  input  logic [WEIGHT_W-1:0] i_wr_data,
  output logic [WEIGHT_W-1:0] o_weight,
  output logic                o_upd
);

  localparam logic [TIMER_W-1:0] AGE_MAX = '1;
  localparam int unsigned W_MAX = 2**WEIGHT_W - 1;

  logic [TIMER_W-1:0]  r_age;
  logic [WEIGHT_W-1:0] r_weight;
  logic [TIMER_W-1:0]  w_dt;
  int unsigned         w_delta;
  logic [WEIGHT_W-1:0] w_next;
  logic                w_upd;

`ifndef STDP_LTD_EN
  logic w_unused_post_age;
  localparam int unsigned W_UNUSED_LTD = LTD_AMP;
  assign w_unused_post_age = ^i_post_age;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_age    <= AGE_MAX;
      r_weight <= WEIGHT_W'(W_INIT);
    end else begin
      if (i_pre)
        r_age <= TIMER_W'(1);
      else if (r_age != AGE_MAX)
        r_age <= r_age + 1'b1;
      r_weight <= w_next;
    end
  end

  // Same-cycle pre and post counts as LTP with dt=0, so the
  // LTD branch is only reachable when post is absent.
  always_comb begin
    w_dt    = i_pre ? '0 : r_age;
    w_delta = 0;
    w_next  = r_weight;
    w_upd   = 1'b0;
    if (i_learn && i_post) begin
      if (32'(w_dt) < WINDOW)
        w_delta = decay(LTP_AMP, 32'(w_dt), TAU_SHIFT);
      if (w_delta != 0) begin
        w_next = WEIGHT_W'(sat_add(32'(r_weight),
                                   w_delta, W_MAX));
        w_upd  = 1'b1;
      end
    end
`ifdef STDP_LTD_EN
    else if (i_learn && i_pre) begin
      if (32'(i_post_age) < WINDOW)
        w_delta = decay(LTD_AMP, 32'(i_post_age),
                        TAU_SHIFT);
      if (w_delta != 0) begin
        w_next = WEIGHT_W'(sat_sub(32'(r_weight),
                                   w_delta));
        w_upd  = 1'b1;
      end
    end
`endif
    if (i_wr) begin
      w_next = i_wr_data;
      w_upd  = 1'b0;
    end
  end

  assign o_weight = r_weight;
  assign o_upd    = w_upd;

endmodule

// File: rtl/stdp_array.sv
// Pair-based STDP learning array: NUM_PRE presynaptic channels into one neuron.
// Ports: i_clk, i_rst, i_pre_spike, i_post_spike, i_learn_en, i_wr_en/i_wr_idx/i_wr_data,
// i_rd_idx, o_rd_weight, o_weights_flat, o_update_valid, o_update_mask.
// Define STDP_LTD_EN to enable the depression (pre-after-post) path.
module stdp_array
  import stdp_pkg::*;
#(
  parameter int unsigned NUM_PRE   = 4,
  parameter int unsigned TIMER_W   = 4,
  parameter int unsigned WEIGHT_W  = 8,
  parameter int unsigned W_INIT    = 128,
  parameter int unsigned LTP_AMP   = 16,
  parameter int unsigned LTD_AMP   = 8,
  parameter int unsigned TAU_SHIFT = 1,
  parameter int unsigned WINDOW    = 8,
  localparam int IDX_W =
    (NUM_PRE > 1) ? clog2(NUM_PRE) : 1
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [NUM_PRE-1:0]          i_pre_spike,
  input  logic                        i_post_spike,
  input  logic                        i_learn_en,
  input  logic                        i_wr_en,
  input  logic [IDX_W-1:0]            i_wr_idx,
  input  logic [WEIGHT_W-1:0]         i_wr_data,
  input  logic [IDX_W-1:0]            i_rd_idx,
  output logic [WEIGHT_W-1:0]         o_rd_weight,
  output logic [NUM_PRE*WEIGHT_W-1:0] o_weights_flat,
  output logic                        o_update_valid,
  output logic [NUM_PRE-1:0]          o_update_mask
);

  localparam logic [TIMER_W-1:0] AGE_MAX = '1;

  logic [TIMER_W-1:0]  r_post_age;
  logic [NUM_PRE-1:0]  r_mask;
  logic [WEIGHT_W-1:0] r_rd;
  logic [WEIGHT_W-1:0] w_weight [NUM_PRE];
  logic [NUM_PRE-1:0]  w_upd;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_post_age <= AGE_MAX;
      r_mask     <= '0;
      r_rd       <= '0;
    end else begin
      if (i_post_spike)
        r_post_age <= TIMER_W'(1);
      else if (r_post_age != AGE_MAX)
        r_post_age <= r_post_age + 1'b1;
      r_mask <= w_upd;
      if (32'(i_rd_idx) < NUM_PRE)
        r_rd <= w_weight[i_rd_idx];
      else
        r_rd <= '0;
    end
  end

  for (genvar g = 0; g < int'(NUM_PRE); g++) begin : g_ch
    stdp_channel #(
      .TIMER_W   (TIMER_W),
      .WEIGHT_W  (WEIGHT_W),
      .W_INIT    (W_INIT),
      .LTP_AMP   (LTP_AMP),
      .LTD_AMP   (LTD_AMP),
      .TAU_SHIFT (TAU_SHIFT),
      .WINDOW    (WINDOW)
    ) u_ch (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_pre      (i_pre_spike[g]),
      .i_post     (i_post_spike),
      .i_learn    (i_learn_en),
      .i_post_age (r_post_age),
      .i_wr       (i_wr_en &&
                   (32'(i_wr_idx) == 32'(g))),
      .i_wr_data  (i_wr_data),
      .o_weight   (w_weight[g]),
      .o_upd      (w_upd[g])
    );
    assign o_weights_flat[g*WEIGHT_W +: WEIGHT_W] =
      w_weight[g];
  end

  assign o_rd_weight    = r_rd;
  assign o_update_mask  = r_mask;
  assign o_update_valid = |r_mask;

endmodule

// File: tb/tb_stdp_array.sv
// Scoreboard bench for stdp_array: directed STDP pair scenarios plus random traffic.
// Honours STDP_LTD_EN the same way the design does.
module tb_stdp_array;

  localparam int NP   = 4;
  localparam int TW   = 4;
  localparam int WW   = 8;
  localparam int WI   = 128;
  localparam int LTP  = 16;
  localparam int LTD  = 8;
  localparam int TAU  = 1;
  localparam int WIN  = 8;
  localparam int AMAX = 15;
  localparam int WMAX = 255;

`ifdef STDP_LTD_EN
  localparam bit LTD_ON = 1'b1;
`else
  localparam bit LTD_ON = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [NP-1:0]     pre;
  logic              post;
  logic              learn;
  logic              wr;
  logic [1:0]        widx;
  logic [WW-1:0]     wdata;
  logic [1:0]        ridx;
  logic [WW-1:0]     rd_w;
  logic [NP*WW-1:0]  flat;
  logic              uvalid;
  logic [NP-1:0]     umask;

  always #5 clk = ~clk;

  stdp_array #(
    .NUM_PRE(NP), .TIMER_W(TW), .WEIGHT_W(WW),
    .W_INIT(WI), .LTP_AMP(LTP), .LTD_AMP(LTD),
    .TAU_SHIFT(TAU), .WINDOW(WIN)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_pre_spike    (pre),
    .i_post_spike   (post),
    .i_learn_en     (learn),
    .i_wr_en        (wr),
    .i_wr_idx       (widx),
    .i_wr_data      (wdata),
    .i_rd_idx       (ridx),
    .o_rd_weight    (rd_w),
    .o_weights_flat (flat),
    .o_update_valid (uvalid),
    .o_update_mask  (umask)
  );

  typedef struct {
    logic [NP*WW-1:0] flat;
    logic [NP-1:0]    mask;
    logic [WW-1:0]    rd;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  int m_w   [NP];
  int m_age [NP];
  int m_pa;

  // Reference: ages count cycles since the last spike (capped),
  // each channel pairs the post spike with its own pre age.
  task automatic cyc(
    input logic          r,
    input logic [NP-1:0] p,
    input logic          q,
    input logic          l,
    input logic          w,
    input int            wi,
    input int            wd,
    input int            ri
  );
    exp_t e;
    int   nw [NP];
    int   mk;
    int   dt;
    int   d;
    @(negedge clk);
    rst   = r;
    pre   = p;
    post  = q;
    learn = l;
    wr    = w;
    widx  = 2'(wi);
    wdata = WW'(wd);
    ridx  = 2'(ri);
    mk    = 0;
    e.rd  = '0;
    if (r) begin
      for (int i = 0; i < NP; i++) begin
        m_w[i]   = WI;
        m_age[i] = AMAX;
      end
      m_pa = AMAX;
    end else begin
      e.rd = WW'(m_w[ri]);
      for (int i = 0; i < NP; i++) begin
        nw[i] = m_w[i];
        if (w && wi == i) begin
          nw[i] = wd;
        end else if (l && q) begin
          dt = p[i] ? 0 : m_age[i];
          d  = (dt < WIN) ? (LTP >> (dt >> TAU)) : 0;
          if (d > 0) begin
            nw[i] = (m_w[i] + d > WMAX) ?
                    WMAX : m_w[i] + d;
            mk = mk | (1 << i);
          end
        end else if (LTD_ON && l && p[i]) begin
          dt = m_pa;
          d  = (dt < WIN) ? (LTD >> (dt >> TAU)) : 0;
          if (d > 0) begin
            nw[i] = (m_w[i] - d < 0) ? 0 : m_w[i] - d;
            mk = mk | (1 << i);
          end
        end
      end
      for (int i = 0; i < NP; i++) begin
        m_w[i] = nw[i];
        if (p[i])
          m_age[i] = 1;
        else if (m_age[i] < AMAX)
          m_age[i] = m_age[i] + 1;
      end
      if (q)
        m_pa = 1;
      else if (m_pa < AMAX)
        m_pa = m_pa + 1;
    end
    for (int i = 0; i < NP; i++)
      e.flat[i*WW +: WW] = WW'(m_w[i]);
    e.mask = NP'(mk);
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++)
      cyc(0, '0, 0, 1, 0, 0, 0, 1);
  endtask

  // Direct check against hand-derived values; called right after a
  // cyc() so the outputs still reflect the previous vector.
  task automatic chk(
    input string         nm,
    input int            ch,
    input int            want,
    input logic [NP-1:0] wm
  );
    logic [WW-1:0] got;
    got = flat[ch*WW +: WW];
    n_vec++;
    if (got !== WW'(want) || umask !== wm ||
        uvalid !== (|wm)) begin
      n_bad++;
      $display("FAIL %s: w%0d=%0d mask=%b valid=%b, want w=%0d mask=%b",
               nm, ch, got, umask, uvalid, want, wm);
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_vec++;
      if (flat !== e.flat || umask !== e.mask ||
          uvalid !== (|e.mask) || rd_w !== e.rd) begin
        n_bad++;
        $display("FAIL sb t=%0t: flat=%h mask=%b valid=%b rd=%0d, want flat=%h mask=%b rd=%0d",
                 $time, flat, umask, uvalid, rd_w,
                 e.flat, e.mask, e.rd);
      end
    end
  end

  initial begin
    logic [NP-1:0] rp;
    rst = 1; pre = '0; post = 0; learn = 1;
    wr = 0; widx = '0; wdata = '0; ridx = '0;

    cyc(1, '0, 0, 1, 0, 0, 0, 0);
    cyc(1, '0, 0, 1, 0, 0, 0, 0);
    idle(1);
    chk("reset", 0, 128, 4'b0000);

    cyc(0, 4'b0001, 0, 1, 0, 0, 0, 0);
    idle(2);
    cyc(0, '0, 1, 1, 0, 0, 0, 0);
    idle(1);
    chk("ltp_dt3", 0, 136, 4'b0001);

    cyc(1, '0, 0, 1, 0, 0, 0, 0);
    cyc(0, 4'b0010, 1, 1, 0, 0, 0, 0);
    idle(1);
    chk("ltp_dt0", 1, 144, 4'b0010);

    cyc(1, '0, 0, 1, 0, 0, 0, 0);
    cyc(0, '0, 1, 1, 0, 0, 0, 0);
    idle(1);
    cyc(0, 4'b0100, 0, 1, 0, 0, 0, 0);
    idle(1);
    chk("ltd_dt2", 2, LTD_ON ? 124 : 128,
        LTD_ON ? 4'b0100 : 4'b0000);

    cyc(1, '0, 0, 1, 0, 0, 0, 0);
    cyc(0, '0, 0, 1, 1, 3, 250, 3);
    cyc(0, 4'b1000, 1, 1, 0, 0, 0, 3);
    idle(1);
    chk("sat_hi", 3, 255, 4'b1000);

    cyc(1, '0, 0, 1, 0, 0, 0, 0);
    cyc(0, '0, 0, 1, 1, 3, 2, 3);
    cyc(0, '0, 1, 1, 0, 0, 0, 3);
    cyc(0, 4'b1000, 0, 1, 0, 0, 0, 3);
    idle(1);
    chk("sat_lo", 3, LTD_ON ? 0 : 2,
        LTD_ON ? 4'b1000 : 4'b0000);

    cyc(1, '0, 0, 1, 0, 0, 0, 0);
    cyc(0, 4'b0001, 0, 1, 0, 0, 0, 0);
    idle(6);
    cyc(0, '0, 1, 1, 0, 0, 0, 0);
    idle(1);
    chk("dt7", 0, 130, 4'b0001);
    cyc(0, 4'b0001, 0, 1, 0, 0, 0, 0);
    idle(7);
    cyc(0, '0, 1, 1, 0, 0, 0, 0);
    idle(1);
    chk("dt8", 0, LTD_ON ? 126 : 130, 4'b0000);
    idle(20);
    cyc(0, 4'b0001, 1, 0, 0, 0, 0, 0);
    idle(1);
    chk("frozen", 0, LTD_ON ? 126 : 130, 4'b0000);

    cyc(1, '0, 0, 1, 0, 0, 0, 0);
    cyc(0, 4'b0001, 0, 1, 0, 0, 0, 1);
    cyc(1, '0, 0, 1, 0, 0, 0, 1);
    idle(1);
    cyc(0, '0, 1, 1, 0, 0, 0, 1);
    idle(1);
    chk("rst_mid", 0, 128, 4'b0000);

    cyc(0, '0, 0, 1, 1, 3, 77, 0);
    cyc(0, '0, 0, 1, 0, 0, 0, 3);
    idle(1);
    n_vec++;
    if (rd_w !== 8'd77) begin
      n_bad++;
      $display("FAIL rd_port: rd=%0d want 77", rd_w);
    end

    for (int k = 0; k < 800; k++) begin
      for (int i = 0; i < NP; i++)
        rp[i] = ($urandom_range(0, 5) == 0);
      cyc(($urandom_range(0, 99) == 0), rp,
          ($urandom_range(0, 4) == 0),
          ($urandom_range(0, 9) != 0),
          ($urandom_range(0, 19) == 0),
          int'($urandom_range(0, NP - 1)),
          ($urandom_range(0, 3) == 0) ?
            ($urandom_range(0, 1) ? 250 : 3) :
            int'($urandom_range(0, 255)),
          int'($urandom_range(0, NP - 1)));
    end

    repeat (2) @(posedge clk);
    #2;
    n_vec++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d left, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
